glitch_sequencer: RTL and testbench

GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

---
 rtl/glitch_sequencer.sv | 137 +++++++++++++
 tb/tb_glitch_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/glitch_sequencer.sv
// Glitch sequencer: holds a target in reset, waits a programmable delay,
// then fires one glitch pulse of programmable width.
module glitch_sequencer #(
  parameter int unsigned RST_CYCLES = 120,
  parameter int unsigned DELAY_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [15:0]        cfg_width,
  output logic               target_rst_n,
  output logic               glitch_out,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CW = (DELAY_W > 16) ? DELAY_W : 16;
  localparam logic [CW-1:0] RST_LOAD = CW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DELAY,
    GLITCH
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DELAY_W-1:0] dly_q, dly_d;
  logic [15:0]        wid_q, wid_d;
  logic               trst_q, trst_d;
  logic               glt_q, glt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state and registered-output logic; counter reaching zero
  // marks the last cycle of the current phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    wid_d   = wid_q;
    trst_d  = trst_q;
    glt_d   = glt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HOLD;
          cnt_d   = RST_LOAD;
          dly_d   = cfg_delay;
          wid_d   = cfg_width;
          trst_d  = 1'b0;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          trst_d = 1'b1;
          if (dly_q != '0) begin
            state_d = DELAY;
            cnt_d   = CW'(dly_q) - 1'b1;
          end else if (wid_q != '0) begin
            state_d = GLITCH;
            glt_d   = 1'b1;
            cnt_d   = CW'(wid_q) - 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      DELAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (wid_q != '0) begin
          state_d = GLITCH;
          glt_d   = 1'b1;
          cnt_d   = CW'(wid_q) - 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      GLITCH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
          glt_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      trst_d  = 1'b1;
      glt_d   = 1'b0;
      done_d  = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  // State, counter, latched config and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dly_q   <= '0;
      wid_q   <= '0;
      trst_q  <= 1'b1;
      glt_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      wid_q   <= wid_d;
      trst_q  <= trst_d;
      glt_q   <= glt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign target_rst_n = trst_q;
  assign glitch_out   = glt_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Bench for glitch_sequencer: edge-timeline model checked every cycle
// plus literal checkpoints on the directed scenarios.
module tb_glitch_sequencer;

  localparam int R = 120;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_delay = '0;
  logic [15:0] cfg_width = '0;
  logic        target_rst_n, glitch_out, busy, done;

  int     tests = 0;
  int     fails = 0;
  longint cyc = -1;

  glitch_sequencer #(.RST_CYCLES(R), .DELAY_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width),
    .target_rst_n(target_rst_n), .glitch_out(glitch_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic got,
                     input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %b, expected %b",
               name, cyc, got, exp);
    end
  endtask

  // Model: an attempt accepted at edge n with latched d,w occupies
  // edges n..n+R+d+w; outputs follow directly from those edge numbers.
  initial begin : model
    bit     act;
    longint n, d, w, fin;
    logic   et, eg, eb, ed;
    act = 0; n = 0; d = 0; w = 0; fin = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        act = 0;
      end else if (!act || cyc > fin) begin
        act = 0;
        if (start) begin
          act = 1; n = cyc;
          d = longint'(cfg_delay);
          w = longint'(cfg_width);
          fin = n + R + d + w;
        end
      end else if (abort) begin
        act = 0;
      end
      et = 1'b1; eg = 1'b0; eb = 1'b0; ed = 1'b0;
      if (act) begin
        et = !(cyc < n + R);
        eg = (cyc >= n + R + d) && (cyc < fin);
        eb = (cyc < fin);
        ed = (cyc == fin);
      end
      #1;
      chk("m_trst", target_rst_n, et);
      chk("m_glitch", glitch_out, eg);
      chk("m_busy", busy, eb);
      chk("m_done", done, ed);
      chk("m_no_glitch_in_rst", glitch_out & ~target_rst_n, 1'b0);
    end
  end

  task automatic step_to(input longint e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  task automatic at(input longint e);
    step_to(e + 1);
  endtask

  task automatic go(input longint e, input int dv, input int wv);
    step_to(e);
    start = 1'b1; cfg_delay = 32'(dv); cfg_width = 16'(wv);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic kill(input longint e);
    step_to(e);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic hit_rst(input longint e, input bit with_start);
    step_to(e);
    rst = 1'b1; start = with_start;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
  endtask

  initial begin : stim
    longint b;
    step_to(3);
    rst = 1'b0;
    // normal run, then back-to-back zero delay/width attempt
    b = 10;
    go(b, 5, 3);
    at(b + 119); chk("s1_trst_low", target_rst_n, 1'b0);
    chk("s1_busy", busy, 1'b1);
    at(b + 120); chk("s1_trst_rise", target_rst_n, 1'b1);
    at(b + 124); chk("s1_glitch_pre", glitch_out, 1'b0);
    at(b + 125); chk("s1_glitch_rise", glitch_out, 1'b1);
    at(b + 127); chk("s1_glitch_hold", glitch_out, 1'b1);
    at(b + 128); chk("s1_glitch_fall", glitch_out, 1'b0);
    chk("s1_done", done, 1'b1);
    chk("s1_busy_low", busy, 1'b0);
    go(b + 129, 0, 0);
    at(b + 129); chk("s2_trst_fall", target_rst_n, 1'b0);
    chk("s2_done_clear", done, 1'b0);
    b = b + 129;
    at(b + 120); chk("s2_trst_rise", target_rst_n, 1'b1);
    chk("s2_done", done, 1'b1);
    chk("s2_no_glitch", glitch_out, 1'b0);
    // abort before glitch, then a fresh attempt
    b = b + 130;
    go(b, 10, 4);
    kill(b + 127);
    at(b + 127); chk("s3_abort_busy", busy, 1'b0);
    chk("s3_abort_trst", target_rst_n, 1'b1);
    go(b + 130, 2, 1);
    b = b + 130;
    at(b + 122); chk("s3_new_glitch", glitch_out, 1'b1);
    at(b + 123); chk("s3_new_done", done, 1'b1);
    // start and config changes while busy are ignored
    b = b + 130;
    go(b, 5, 3);
    go(b + 50, 7, 9);
    go(b + 122, 1, 1);
    at(b + 125); chk("s4_glitch", glitch_out, 1'b1);
    at(b + 128); chk("s4_done", done, 1'b1);
    // reset mid-glitch
    b = b + 135;
    go(b, 5, 3);
    hit_rst(b + 126, 1'b1);
    at(b + 126); chk("s5_rst_glitch", glitch_out, 1'b0);
    chk("s5_rst_busy", busy, 1'b0);
    at(b + 128); chk("s5_no_done", done, 1'b0);
    // zero width with nonzero delay
    b = b + 135;
    go(b, 3, 0);
    at(b + 123); chk("s6_done", done, 1'b1);
    // abort in HOLD, abort in IDLE, rst overriding start
    b = b + 130;
    go(b, 4, 4);
    kill(b + 50);
    at(b + 50); chk("s7_abort_hold", target_rst_n, 1'b1);
    kill(b + 55);
    at(b + 55); chk("s7_abort_idle", busy, 1'b0);
    hit_rst(b + 60, 1'b1);
    at(b + 60); chk("s7_rst_over_start", busy, 1'b0);
    at(b + 70);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
